calc_result_accum: RTL and testbench

//  Downstream consumer of the 12a+5b multiplier stage. Captures each 9-bit

---
 rtl/calc_result_accum.sv | 159 +++++++++++++++
 tb/tb_calc_result_accum.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_result_accum.sv
// ---------------------------------------------------------------------------
// calc_result_accum
//   Consumes 9-bit results from the multiplier stage and buffers them in a
//   small FIFO. It sums each run of GROUP consecutive results and tracks the
//   maximum of that run. The group total and maximum are presented on a
//   valid/ready output. The producer cannot be stalled, so a full FIFO drops
//   the incoming sample and raises a sticky overflow flag.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   clr        synchronous flush of FIFO, accumulator, overflow and FSM
//   c          incoming result
//   c_valid    c carries a new result this cycle
//   out_sum    sum of the GROUP results of the finished group
//   out_max    largest (unsigned) result of that group
//   out_valid  out_sum/out_max are valid
//   out_ready  consumer accepts on out_valid && out_ready
//   fifo_level current FIFO occupancy (0..FIFO_DEPTH)
//   overflow   sticky: a valid sample was dropped
//
// Handshake: a group result transfers on the rising edge where out_valid and
// out_ready are both high. out_valid, out_sum and out_max stay stable until
// that edge, and out_valid never depends on out_ready.
// ---------------------------------------------------------------------------
module calc_result_accum #(
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 4,
  parameter int GROUP      = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clr,
  input  logic [DATA_W-1:0]                 c,
  input  logic                              c_valid,
  output logic [DATA_W+$clog2(GROUP)-1:0]   out_sum,
  output logic [DATA_W-1:0]                 out_max,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
  output logic                              overflow
);

  localparam int SUM_W = DATA_W + $clog2(GROUP);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(GROUP);

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [SUM_W-1:0]  sum, sum_next;
  logic [DATA_W-1:0] max_val, max_next;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] head;
  logic              full, empty, pop, push, drop, last_pop, handshake;

  assign head  = mem[rd_ptr];
  assign full  = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign empty = (fifo_level == '0);

  // clr overrides everything, so it masks every update strobe.
  assign pop       = (state == ACC) && !empty && !clr;
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign push      = c_valid && (!full || pop) && !clr;
  assign drop      = c_valid && full && !pop && !clr;
  assign last_pop  = pop && (count == CNT_W'(GROUP - 1));
  assign handshake = (state == DONE) && out_valid && out_ready && !clr;

  assign sum_next = sum + SUM_W'(head);
  assign max_next = (head > max_val) ? head : max_val;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACC;
    else     state <= state_next;
  end

  // FSM next state
  always_comb begin
    state_next = state;
    if (clr) begin
      state_next = ACC;
    end else begin
      case (state)
        ACC:     if (last_pop)  state_next = DONE;
        DONE:    if (handshake) state_next = ACC;
        default: state_next = ACC;
      endcase
    end
  end

  // FIFO storage: contents need no reset, the pointers and level guard them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= c;
  end

  // Pointers, level, accumulator and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      sum        <= '0;
      max_val    <= '0;
      count      <= '0;
      out_sum    <= '0;
      out_max    <= '0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
    end else if (clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      sum        <= '0;
      max_val    <= '0;
      count      <= '0;
      out_sum    <= '0;
      out_max    <= '0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);

      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        if (last_pop) begin
          // Publish the completed group and start the next one from zero.
          out_sum   <= sum_next;
          out_max   <= max_next;
          out_valid <= 1'b1;
          sum       <= '0;
          max_val   <= '0;
          count     <= '0;
        end else begin
          sum     <= sum_next;
          max_val <= max_next;
          count   <= count + CNT_W'(1);
        end
      end

      if (handshake) out_valid <= 1'b0;
      if (drop)      overflow  <= 1'b1;

      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_result_accum.sv
module tb_calc_result_accum;

  localparam int DATA_W     = 9;
  localparam int FIFO_DEPTH = 4;
  localparam int GROUP      = 4;
  localparam int SUM_W      = 11;
  localparam int LVL_W      = 3;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              clr;
  logic [DATA_W-1:0] c;
  logic              c_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  out_sum;
  logic [DATA_W-1:0] out_max;
  logic              out_valid;
  logic [LVL_W-1:0]  fifo_level;
  logic              overflow;

  always #5 clk = ~clk;

  calc_result_accum #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .GROUP(GROUP)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .c          (c),
    .c_valid    (c_valid),
    .out_sum    (out_sum),
    .out_max    (out_max),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  logic [31:0] dut_pack;
  assign dut_pack = {7'd0, out_valid, out_sum, out_max, fifo_level, overflow};

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- scoreboard + reference model ----------------
  typedef logic [SUM_W+DATA_W-1:0] sb_t;
  sb_t exp_q[$];

  int unsigned m_q[$];    // FIFO contents
  int unsigned m_grp[$];  // results collected for the current group
  bit          m_valid;
  bit          m_ovf;
  int unsigned m_sum;
  int unsigned m_max;

  function automatic logic [31:0] model_pack();
    return {7'd0, m_valid, SUM_W'(m_sum), DATA_W'(m_max), LVL_W'(m_q.size()), m_ovf};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_grp.delete();
    exp_q.delete();
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_sum   = 0;
    m_max   = 0;
  endtask

  // One clock edge of behaviour, expressed with queues and plain arithmetic.
  task automatic model_edge(input bit cv, input int unsigned cin, input bit cl, input bit rdy);
    bit pop_now, hs;
    int unsigned s, mx;
    if (cl) begin
      model_reset();
      return;
    end
    pop_now = !m_valid && (m_q.size() > 0);
    hs      = m_valid && rdy;
    if (pop_now) begin
      m_grp.push_back(m_q.pop_front());
      if (m_grp.size() == GROUP) begin
        s  = 0;
        mx = 0;
        foreach (m_grp[i]) begin
          s += m_grp[i];
          if (m_grp[i] > mx) mx = m_grp[i];
        end
        m_sum   = s;
        m_max   = mx;
        m_valid = 1'b1;
        exp_q.push_back({SUM_W'(s), DATA_W'(mx)});
        m_grp.delete();
      end
    end
    if (cv) begin
      if (m_q.size() < FIFO_DEPTH) m_q.push_back(cin);
      else                         m_ovf = 1'b1;
    end
    if (hs) m_valid = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit cv, input logic [DATA_W-1:0] cin, input bit cl, input bit rdy);
    sb_t got;
    c_valid   = cv;
    c         = cin;
    clr       = cl;
    out_ready = rdy;
    // Outputs are stable here (set 1 time unit after the previous edge).
    if (out_valid && rdy && !cl) begin
      got = {out_sum, out_max};
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL scoreboard: got %0h with no expected group pending", got);
      end else begin
        check("scoreboard", 32'(got), 32'(exp_q.pop_front()));
      end
    end
    @(posedge clk);
    model_edge(cv, 32'(cin), cl, rdy);
    #1;
    check("cycle", dut_pack, model_pack());
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit                cv;
    logic [DATA_W-1:0] c;
    bit                rdy;
    bit                e_valid;
    logic [SUM_W-1:0]  e_sum;
    logic [DATA_W-1:0] e_max;
    logic [LVL_W-1:0]  e_lvl;
    bit                e_ovf;
  } vec_t;

  vec_t tbl[12];

  task automatic set_row(input int i, input bit cv, input int unsigned cin, input bit rdy,
                         input bit ev, input int unsigned es, input int unsigned em,
                         input int unsigned el, input bit eo);
    tbl[i].cv      = cv;
    tbl[i].c       = DATA_W'(cin);
    tbl[i].rdy     = rdy;
    tbl[i].e_valid = ev;
    tbl[i].e_sum   = SUM_W'(es);
    tbl[i].e_max   = DATA_W'(em);
    tbl[i].e_lvl   = LVL_W'(el);
    tbl[i].e_ovf   = eo;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // group of 10,20,30,40 then a group of four 511s
    set_row(0,  1, 10,  1, 0, 0,    0,   1, 0);
    set_row(1,  1, 20,  1, 0, 0,    0,   1, 0);
    set_row(2,  1, 30,  1, 0, 0,    0,   1, 0);
    set_row(3,  1, 40,  1, 0, 0,    0,   1, 0);
    set_row(4,  0, 0,   1, 1, 100,  40,  0, 0);
    set_row(5,  0, 0,   1, 0, 100,  40,  0, 0);
    set_row(6,  1, 511, 1, 0, 100,  40,  1, 0);
    set_row(7,  1, 511, 1, 0, 100,  40,  1, 0);
    set_row(8,  1, 511, 1, 0, 100,  40,  1, 0);
    set_row(9,  1, 511, 1, 0, 100,  40,  1, 0);
    set_row(10, 0, 0,   1, 1, 2044, 511, 0, 0);
    set_row(11, 0, 0,   1, 0, 2044, 511, 0, 0);

    // reset
    rst = 1'b1; clr = 1'b0; c_valid = 1'b0; c = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset", dut_pack, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // table: basic group, 1-cycle valid, width limit
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].cv, tbl[i].c, 1'b0, tbl[i].rdy);
      check($sformatf("table[%0d]", i), dut_pack,
            {7'd0, tbl[i].e_valid, tbl[i].e_sum, tbl[i].e_max, tbl[i].e_lvl, tbl[i].e_ovf});
    end

    // stalled consumer: fill FIFO, drop the 5th sample, then drain
    for (int i = 1; i <= 4; i++) step(1'b1, DATA_W'(i * 10), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("stall_valid", 32'(out_valid), 32'd1);
    for (int i = 1; i <= 5; i++) step(1'b1, DATA_W'(i), 1'b0, 1'b0);
    check("stall_level", 32'(fifo_level), 32'd4);
    check("stall_ovf",   32'(overflow),   32'd1);
    check("stall_hold",  32'(out_sum),    32'd100);
    step(1'b0, '0, 1'b0, 1'b1);
    check("stall_hs_valid", 32'(out_valid), 32'd0);
    check("stall_hs_level", 32'(fifo_level), 32'd4);
    repeat (4) step(1'b0, '0, 1'b0, 1'b0);
    check("stall_sum", 32'(out_sum), 32'd10);
    check("stall_max", 32'(out_max), 32'd4);
    step(1'b0, '0, 1'b0, 1'b1);

    // full FIFO in ACC: push and pop on the same edge
    step(1'b0, '0, 1'b1, 1'b0);
    check("clr_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, DATA_W'(7), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) step(1'b1, DATA_W'(i), 1'b0, 1'b0);
    check("full_level", 32'(fifo_level), 32'd4);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, DATA_W'(9), 1'b0, 1'b0);
    check("pushpop_level", 32'(fifo_level), 32'd4);
    check("pushpop_ovf",   32'(overflow),   32'd0);
    repeat (3) step(1'b0, '0, 1'b0, 1'b0);
    check("pushpop_sum", 32'(out_sum), 32'd10);
    step(1'b0, '0, 1'b0, 1'b1);

    // clr together with a sample, then a fresh group
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, DATA_W'(1), 1'b0, 1'b1);
    step(1'b1, DATA_W'(2), 1'b0, 1'b1);
    step(1'b1, DATA_W'(3), 1'b1, 1'b1);
    check("clr_level", 32'(fifo_level), 32'd0);
    check("clr_ovf2",  32'(overflow),   32'd0);
    for (int i = 1; i <= 4; i++) step(1'b1, DATA_W'(i), 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("clr_sum", 32'(out_sum), 32'd10);
    check("clr_max", 32'(out_max), 32'd4);
    step(1'b0, '0, 1'b0, 1'b1);

    // asynchronous reset mid-group
    step(1'b1, DATA_W'(8), 1'b0, 1'b1);
    step(1'b1, DATA_W'(9), 1'b0, 1'b1);
    #3;
    c_valid = 1'b0;
    rst     = 1'b1;
    #1;
    check("async_rst", dut_pack, 32'd0);
    model_reset();
    #2;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, DATA_W'(5), 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("rst_sum", 32'(out_sum), 32'd20);
    step(1'b0, '0, 1'b0, 1'b1);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [DATA_W-1:0] rv;
      case ($urandom_range(0, 7))
        0:       rv = '1;
        1:       rv = '0;
        default: rv = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
      endcase
      step($urandom_range(0, 9) < 7, rv, $urandom_range(0, 59) == 0,
           (i % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
